spmm_stream_engine: RTL
=======================

// Module: spmm_stream_engine
// PURPOSE
// Parametrised successor of the CSR sparse x dense (H x W) multiply stage in the GAT front end.
// Consumes one node-info record and then that row's nonzeros over valid/ready streams.
// Runs NUM_COLS parallel signed MAC lanes against one wide weight-row read per nonzero.
// Emits one WH record per row with output backpressure, configurable fixed-point scaling, saturation and empty-row support.
// PARAMETERS
// DATA_WIDTH    8      signed width of H values, W entries and WH results
// NUM_COLS      16     output columns = MAC lanes (W_NUM_OF_COLS)
// H_NUM_COLS    1433   H columns = W rows; COL_IDX_W = $clog2(H_NUM_COLS)
// MAX_ROW_LEN   1433   max nonzeros per row; ROW_LEN_W = $clog2(MAX_ROW_LEN)+1
// NUM_NODE_W    9      width of num_of_nodes field
// WH_DEPTH      13264  WH address space; WH_ADDR_W = $clog2(WH_DEPTH)
// FRAC_BITS     0      arithmetic right shift applied to accumulator before narrowing
// SATURATE      1      1: clamp to signed DATA_WIDTH range; 0: keep low DATA_WIDTH bits
// ACC_W         2*DATA_WIDTH+$clog2(MAX_ROW_LEN)   lane accumulator width (derived)
// PORTS
// clk              in   1                      single clock, all logic on rising edge
// rst              in   1                      synchronous, active-high reset
// info_valid_i     in   1                      node-info record valid
// info_ready_o     out  1                      node-info accepted when valid&ready
// info_row_len_i   in   ROW_LEN_W              nonzeros in this row (0 allowed)
// info_num_nodes_i in   NUM_NODE_W             passed through to WH record
// info_src_flag_i  in   1                      passed through to WH record
// nz_valid_i       in   1                      nonzero valid
// nz_ready_o       out  1                      nonzero accepted when valid&ready
// nz_col_idx_i     in   COL_IDX_W              column index of nonzero
// nz_value_i       in   DATA_WIDTH             signed value of nonzero
// w_rd_en_o        out  1                      weight-row read strobe
// w_addr_o         out  COL_IDX_W              weight row address (= nz_col_idx_i)
// w_dout_i         in   NUM_COLS*DATA_WIDTH    weight row, lane 0 in LSBs, valid 1 cycle after w_rd_en_o
// wh_valid_o       out  1                      WH record valid
// wh_ready_i       in   1                      downstream accepts record
// wh_data_o        out  NUM_COLS*DATA_WIDTH+NUM_NODE_W+1  {lane NUM_COLS-1 .. lane 0, num_nodes, src_flag}
// wh_addr_o        out  WH_ADDR_W              WH write address of current record
// busy_o           out  1                      state != IDLE
// BEHAVIOUR
// - Reset: state IDLE; accumulators, wh_data_o, wh_addr_o, wh_valid_o, w_rd_en_o, busy_o = 0.
// - Reset mid-row discards in-flight row; no partial record emitted.
// - FSM IDLE: info_ready_o=1. On accept, latch len/num_nodes/flag and clear accumulators.
//   len==0 -> OUT (all lanes 0). Otherwise -> ACC with remaining=len.
// - FSM ACC: nz_ready_o=1.
//   Each accepted nz: w_rd_en_o=1 and w_addr_o=col_idx in the same cycle, value registered, remaining--.
//   nz_valid_i low stalls with no read and no MAC.
//   Accepting the nz that takes remaining to 0 -> DRAIN.
// - MAC: the cycle after each read, acc[k] += value * w_dout_i[lane k], full signed product, no overflow inside ACC_W.
// - FSM DRAIN: 1 cycle, final MAC lands; narrowed results registered -> OUT.
// - FSM OUT: wh_valid_o=1 and wh_data_o stable until wh_ready_i.
//   On handshake: wh_addr_o += 1, wrapping WH_DEPTH-1 -> 0; state -> IDLE.
// - info_ready_o and nz_ready_o are 0 outside IDLE/ACC respectively; nz beats offered in IDLE are not consumed.
// - Latency: info accepted cycle 0, nz at cycles 1..L without stalls, wh_valid_o rises cycle L+2. Empty row: cycle 1.
// - Narrowing per lane: s = acc >>> FRAC_BITS.
//   SATURATE=1 -> clamp to [-2^(DW-1), 2^(DW-1)-1]. SATURATE=0 -> s[DW-1:0].
// - Throughput: 1 nz/cycle within a row; row overhead 3 cycles plus any backpressure.
// TESTING
// - Row len=3, vals {1,2,3}, W rows = lane index k -> wh_data lane k = 6k; wh_valid_o at cycle 5; wh_addr_o 0 then 1.
// - Row len=0, num_nodes=5, flag=1 -> wh_valid_o at cycle 1; all lanes 0; fields 5 and 1.
// - SATURATE=1, DW=8: 4 nz of 127 with W=127 -> lanes 127. Same with -128 x 127 -> lanes -128.
// - SATURATE=0, DW=8: same 127 stimulus -> lanes = low 8 bits of 64516 (0x04).
// - FRAC_BITS=4: value 16, W 3 -> lanes 3.
// - wh_ready_i low 10 cycles -> record held stable, info_ready_o=0.
// - nz_valid_i gaps -> result unchanged vs gap-free run.
// - WH_DEPTH=4, 5 rows -> addresses 0,1,2,3,0.
// - rst asserted during ACC of row 2 -> no record for row 2; next row gets wh_addr_o 0 and correct sums.

Source files
------------

// File: rtl/spmm_stream_engine.sv
// spmm_stream_engine: CSR sparse-row x dense weight multiply stage.
// Takes one node-info record, then that row's nonzeros. Each nonzero triggers a
// wide weight-row read, and NUM_COLS signed MAC lanes accumulate the products.
// When the row is done, one WH record is emitted with backpressure. The record
// is built by narrowing each lane: arithmetic shift, then saturate or truncate.
module spmm_stream_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_COLS    = 16,
  parameter int H_NUM_COLS  = 1433,
  parameter int MAX_ROW_LEN = 1433,
  parameter int NUM_NODE_W  = 9,
  parameter int WH_DEPTH    = 13264,
  parameter int FRAC_BITS   = 0,
  parameter int SATURATE    = 1,
  localparam int COL_IDX_W  = $clog2(H_NUM_COLS),
  localparam int ROW_LEN_W  = $clog2(MAX_ROW_LEN) + 1,
  localparam int WH_ADDR_W  = $clog2(WH_DEPTH),
  localparam int ACC_W      = 2 * DATA_WIDTH + $clog2(MAX_ROW_LEN),
  localparam int WH_W       = NUM_COLS * DATA_WIDTH + NUM_NODE_W + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           info_valid_i,
  output logic                           info_ready_o,
  input  logic [ROW_LEN_W-1:0]           info_row_len_i,
  input  logic [NUM_NODE_W-1:0]          info_num_nodes_i,
  input  logic                           info_src_flag_i,
  input  logic                           nz_valid_i,
  output logic                           nz_ready_o,
  input  logic [COL_IDX_W-1:0]           nz_col_idx_i,
  input  logic [DATA_WIDTH-1:0]          nz_value_i,
  output logic                           w_rd_en_o,
  output logic [COL_IDX_W-1:0]           w_addr_o,
  input  logic [NUM_COLS*DATA_WIDTH-1:0] w_dout_i,
  output logic                           wh_valid_o,
  input  logic                           wh_ready_i,
  output logic [WH_W-1:0]                wh_data_o,
  output logic [WH_ADDR_W-1:0]           wh_addr_o,
  output logic                           busy_o
);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  state_t                           state, state_next;
  logic [ROW_LEN_W-1:0]             remaining;
  logic [NUM_NODE_W-1:0]            num_nodes_q;
  logic                             flag_q;
  logic signed [DATA_WIDTH-1:0]     val_q;
  logic                             mac_pend;
  logic signed [ACC_W-1:0]          acc      [NUM_COLS];
  logic signed [ACC_W-1:0]          acc_next [NUM_COLS];
  logic signed [ACC_W-1:0]          shifted  [NUM_COLS];
  logic [NUM_COLS*DATA_WIDTH-1:0]   lanes_q, lanes_next;
  logic [WH_ADDR_W-1:0]             wh_addr_q;
  logic                             info_fire, nz_fire, wh_fire;

  assign info_fire  = info_valid_i & info_ready_o;
  assign nz_fire    = nz_valid_i & nz_ready_o;
  assign wh_fire    = wh_valid_o & wh_ready_i;
  assign w_rd_en_o  = nz_fire;
  assign w_addr_o   = nz_col_idx_i;
  assign wh_valid_o = (state == OUT);
  assign busy_o     = (state != IDLE);
  assign wh_data_o  = {lanes_q, num_nodes_q, flag_q};
  assign wh_addr_o  = wh_addr_q;

  // State register; reset abandons any row in flight
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake readies
  always_comb begin
    state_next   = state;
    info_ready_o = 1'b0;
    nz_ready_o   = 1'b0;
    case (state)
      IDLE: begin
        info_ready_o = 1'b1;
        if (info_valid_i) state_next = (info_row_len_i == '0) ? OUT : ACC;
      end
      ACC: begin
        nz_ready_o = 1'b1;
        if (nz_valid_i && remaining == ROW_LEN_W'(1)) state_next = DRAIN;
      end
      DRAIN: state_next = OUT;
      OUT:   if (wh_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane accumulate: the product of the value and weight read on the previous cycle
  always_comb begin
    for (int k = 0; k < NUM_COLS; k++) begin
      acc_next[k] = acc[k];
      if (mac_pend)
        acc_next[k] = acc[k] + ACC_W'(val_q) *
                      ACC_W'($signed(w_dout_i[k*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  // Narrow each lane: shift out the fraction, then clamp or keep the low bits
  always_comb begin
    lanes_next = '0;
    for (int k = 0; k < NUM_COLS; k++) begin
      shifted[k] = acc_next[k] >>> FRAC_BITS;
      if (SATURATE != 0) begin
        if (shifted[k] > SAT_MAX)      shifted[k] = SAT_MAX;
        else if (shifted[k] < SAT_MIN) shifted[k] = SAT_MIN;
      end
      lanes_next[k*DATA_WIDTH +: DATA_WIDTH] = shifted[k][DATA_WIDTH-1:0];
    end
  end

  // Row bookkeeping: latch the record header, count nonzeros, stage value for MAC
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining   <= '0;
      num_nodes_q <= '0;
      flag_q      <= 1'b0;
      val_q       <= '0;
      mac_pend    <= 1'b0;
    end else begin
      mac_pend <= nz_fire;
      if (nz_fire) begin
        val_q     <= nz_value_i;
        remaining <= remaining - ROW_LEN_W'(1);
      end
      if (info_fire) begin
        remaining   <= info_row_len_i;
        num_nodes_q <= info_num_nodes_i;
        flag_q      <= info_src_flag_i;
      end
    end
  end

  // Accumulators and output lanes; cleared when a new row is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_COLS; k++) acc[k] <= '0;
      lanes_q <= '0;
    end else if (info_fire) begin
      for (int k = 0; k < NUM_COLS; k++) acc[k] <= '0;
      lanes_q <= '0;
    end else begin
      for (int k = 0; k < NUM_COLS; k++) acc[k] <= acc_next[k];
      if (state == DRAIN) lanes_q <= lanes_next;
    end
  end

  // WH write address advances once per delivered record, wrapping at the depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wh_addr_q <= '0;
    end else if (wh_fire) begin
      if (wh_addr_q == WH_ADDR_W'(WH_DEPTH - 1)) wh_addr_q <= '0;
      else                                       wh_addr_q <= wh_addr_q + WH_ADDR_W'(1);
    end
  end

endmodule
